// File: rtl/alu_wb_stage_pkg.sv
// Definitions shared by the writeback stage, its write buffer and the ALU:
// flag bit positions, register index width and RF write-port source priority.
package alu_wb_stage_pkg;

  localparam int REG_IDX_W = 4;
  localparam int FLAG_W    = 8;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    RF_SRC_NONE = 2'd0,
    RF_SRC_MEM  = 2'd1,
    RF_SRC_BUF  = 2'd2
  } rf_src_e;

  // Load data always owns the RF port; buffered ALU results only use idle cycles.
  function automatic rf_src_e rf_select(input logic mem_valid, input logic buf_pending);
    if (mem_valid) begin
      return RF_SRC_MEM;
    end
    if (buf_pending) begin
      return RF_SRC_BUF;
    end
    return RF_SRC_NONE;
  endfunction

endpackage

// File: rtl/alu_wb_stage_if.sv
// ALU-to-writeback result channel: valid/ready handshake plus result payload.
interface alu_wb_stage_if
  import alu_wb_stage_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int RWIDTH = REG_IDX_W
);
  logic              in_valid;
  logic              in_ready;
  logic [RWIDTH-1:0] in_ra;
  logic [WIDTH-1:0]  in_res;
  logic [FLAG_W-1:0] in_fo;
  logic              in_wb_en;
  logic              in_flag_en;

  modport master (
    output in_valid, in_ra, in_res, in_fo, in_wb_en, in_flag_en,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_ra, in_res, in_fo, in_wb_en, in_flag_en,
    output in_ready
  );
endinterface

// File: rtl/alu_wb_stage_wb_fifo.sv
// Pending register-file write buffer: DEPTH x {ra,data} FIFO with a
// youngest-match lookup used for operand forwarding.
module wb_fifo
  import alu_wb_stage_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int RWIDTH = REG_IDX_W,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [RWIDTH-1:0]      push_ra,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [RWIDTH-1:0]      head_ra,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  input  logic [RWIDTH-1:0]      chk_ra,
  output logic                   chk_hit,
  output logic [WIDTH-1:0]       chk_data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic [RWIDTH-1:0] ra_mem_q   [DEPTH];
  logic [WIDTH-1:0]  data_mem_q [DEPTH];
  logic [PW-1:0]     ent_age    [DEPTH];
  logic [DEPTH-1:0]  ent_match;
  logic [PW-1:0]     best_age;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: validity comes only from count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      ra_mem_q[wr_ptr_q]   <= push_ra;
      data_mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_ra   = ra_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];
  assign count     = count_q;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ent
      localparam logic [PW-1:0] IDX = PW'(gi);
      assign ent_age[gi]   = IDX - rd_ptr_q;
      assign ent_match[gi] = ({1'b0, ent_age[gi]} < count_q) && (ra_mem_q[gi] == chk_ra);
    end
  endgenerate

  // Highest age relative to the read pointer is the youngest write.
  always_comb begin
    chk_hit  = 1'b0;
    chk_data = '0;
    best_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_match[i] && (!chk_hit || ent_age[i] > best_age)) begin
        chk_hit  = 1'b1;
        best_age = ent_age[i];
        chk_data = data_mem_q[i];
      end
    end
  end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: flag register, result handshake, buffered RF writes
// sharing the single RF port with memory loads, and forwarding lookup.
module alu_wb_stage
  import alu_wb_stage_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int RWIDTH = REG_IDX_W,
  parameter int DEPTH  = 2
) (
  input  logic               clk,
  input  logic               reset,
  alu_wb_stage_if.slave      in_if,
  input  logic               mem_wr_valid,
  input  logic [RWIDTH-1:0]  mem_wr_ra,
  input  logic [WIDTH-1:0]   mem_wr_data,
  output logic               rf_we,
  output logic [RWIDTH-1:0]  rf_wa,
  output logic [WIDTH-1:0]   rf_wd,
  output logic [FLAG_W-1:0]  flags,
  input  logic [RWIDTH-1:0]  chk_ra,
  output logic               chk_hit,
  output logic [WIDTH-1:0]   chk_data,
  output logic               empty
);

  logic [$clog2(DEPTH):0] fifo_count;
  logic [RWIDTH-1:0]      head_ra;
  logic [WIDTH-1:0]       head_data;
  logic                   accept;
  logic                   push;
  logic                   pop;
  rf_src_e                rf_src;
  logic [FLAG_W-1:0]      flags_q, flags_d;

  // DEPTH is a power of two, so the count MSB is set exactly when full.
  assign in_if.in_ready = ~fifo_count[$clog2(DEPTH)];
  assign accept         = in_if.in_valid & in_if.in_ready;
  assign push           = accept & in_if.in_wb_en;
  assign empty          = (fifo_count == '0);
  assign rf_src         = rf_select(mem_wr_valid, ~empty);
  assign pop            = (rf_src == RF_SRC_BUF);

  wb_fifo #(
    .WIDTH  (WIDTH),
    .RWIDTH (RWIDTH),
    .DEPTH  (DEPTH)
  ) u_wb_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_ra   (in_if.in_ra),
    .push_data (in_if.in_res),
    .pop       (pop),
    .head_ra   (head_ra),
    .head_data (head_data),
    .count     (fifo_count),
    .chk_ra    (chk_ra),
    .chk_hit   (chk_hit),
    .chk_data  (chk_data)
  );

  always_comb begin
    rf_we = 1'b0;
    rf_wa = '0;
    rf_wd = '0;
    case (rf_src)
      RF_SRC_MEM: begin
        rf_we = 1'b1;
        rf_wa = mem_wr_ra;
        rf_wd = mem_wr_data;
      end
      RF_SRC_BUF: begin
        rf_we = 1'b1;
        rf_wa = head_ra;
        rf_wd = head_data;
      end
      default: begin
        rf_we = 1'b0;
      end
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (accept && in_if.in_flag_en) begin
      flags_d = in_if.in_fo;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: directed scenarios plus randomized
// traffic compared against a queue-based model of the write buffer.
module tb_alu_wb_stage;

  localparam int WIDTH  = 32;
  localparam int RWIDTH = 4;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_wr_valid;
  logic [RWIDTH-1:0] mem_wr_ra;
  logic [WIDTH-1:0]  mem_wr_data;
  logic              rf_we;
  logic [RWIDTH-1:0] rf_wa;
  logic [WIDTH-1:0]  rf_wd;
  logic [7:0]        flags;
  logic [RWIDTH-1:0] chk_ra;
  logic              chk_hit;
  logic [WIDTH-1:0]  chk_data;
  logic              empty;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [RWIDTH-1:0] ra;
    logic [WIDTH-1:0]  d;
  } ent_t;

  ent_t       q[$];
  logic [7:0] m_flags = 8'h00;

  always #5 clk = ~clk;

  alu_wb_stage_if #(.WIDTH(WIDTH), .RWIDTH(RWIDTH)) bus ();

  alu_wb_stage #(.WIDTH(WIDTH), .RWIDTH(RWIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_if        (bus),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_ra    (mem_wr_ra),
    .mem_wr_data  (mem_wr_data),
    .rf_we        (rf_we),
    .rf_wa        (rf_wa),
    .rf_wd        (rf_wd),
    .flags        (flags),
    .chk_ra       (chk_ra),
    .chk_hit      (chk_hit),
    .chk_data     (chk_data),
    .empty        (empty)
  );

  task automatic idle();
    bus.in_valid   = 1'b0;
    bus.in_ra      = '0;
    bus.in_res     = '0;
    bus.in_fo      = '0;
    bus.in_wb_en   = 1'b0;
    bus.in_flag_en = 1'b0;
    mem_wr_valid   = 1'b0;
    mem_wr_ra      = '0;
    mem_wr_data    = '0;
    chk_ra         = '0;
  endtask

  task automatic drive_in(input logic [3:0] ra, input logic [31:0] res, input logic [7:0] fo,
                          input logic wb, input logic fe);
    bus.in_valid   = 1'b1;
    bus.in_ra      = ra;
    bus.in_res     = res;
    bus.in_fo      = fo;
    bus.in_wb_en   = wb;
    bus.in_flag_en = fe;
  endtask

  // Advance one clock; the model applies the same edge from the captured inputs.
  task automatic tick();
    bit         acc, pp, wb, fe;
    logic [3:0]  ra;
    logic [31:0] res;
    logic [7:0]  fo;
    acc = bus.in_valid && (q.size() < DEPTH);
    pp  = !mem_wr_valid && (q.size() > 0);
    wb  = bus.in_wb_en;
    fe  = bus.in_flag_en;
    ra  = bus.in_ra;
    res = bus.in_res;
    fo  = bus.in_fo;
    @(posedge clk);
    if (reset) begin
      if (acc) $display("txn t=%0t ra=%0d res=%h fo=%h wb=%0d fe=%0d", $time, ra, res, fo, wb, fe);
      if (pp) void'(q.pop_front());
      if (acc && wb) q.push_back('{ra, res});
      if (acc && fe) m_flags = fo;
    end else begin
      q.delete();
      m_flags = 8'h00;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    mem_wr_valid = 1'b1;
    mem_wr_ra    = 4'd9;
    #1;
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL reset_rf_we_mem got=%b exp=1", rf_we); end
    mem_wr_valid = 1'b0;
    #1;
    total++; if (flags !== 8'h00) begin bad++; $display("FAIL reset_flags got=%h exp=00", flags); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.in_ready); end
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
    total++; if (chk_hit !== 1'b0 || chk_data !== 32'h0) begin bad++; $display("FAIL reset_chk got=%b/%h exp=0/0", chk_hit, chk_data); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    idle();
    chk_ra = 4'd3;
    drive_in(4'd3, 32'h1234, 8'h05, 1'b1, 1'b1);
    #1;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL basic_no_bypass got=%b exp=0", rf_we); end
    total++; if (chk_hit !== 1'b0) begin bad++; $display("FAIL basic_in_not_scanned got=%b exp=0", chk_hit); end
    tick();
    bus.in_valid = 1'b0;
    #1;
    total++; if (flags !== 8'h05) begin bad++; $display("FAIL basic_flags got=%h exp=05", flags); end
    total++; if (chk_hit !== 1'b1 || chk_data !== 32'h1234) begin bad++; $display("FAIL basic_chk got=%b/%h exp=1/1234", chk_hit, chk_data); end
    total++; if (rf_we !== 1'b1 || rf_wa !== 4'd3 || rf_wd !== 32'h1234) begin bad++; $display("FAIL basic_rf got=%b/%h/%h exp=1/3/1234", rf_we, rf_wa, rf_wd); end
    tick();
    #1;
    total++; if (empty !== 1'b1 || rf_we !== 1'b0) begin bad++; $display("FAIL basic_drained got=%b/%b exp=1/0", empty, rf_we); end
  endtask

  task automatic test_mem_priority();
    idle();
    mem_wr_valid = 1'b1;
    mem_wr_ra    = 4'd7;
    mem_wr_data  = 32'hAAAA_0007;
    drive_in(4'd2, 32'h22, 8'h00, 1'b1, 1'b0);
    #1;
    total++; if (rf_wa !== 4'd7 || rf_wd !== 32'hAAAA_0007) begin bad++; $display("FAIL mem_c1 got=%h/%h exp=7/aaaa0007", rf_wa, rf_wd); end
    tick();
    drive_in(4'd9, 32'h99, 8'h00, 1'b1, 1'b0);
    #1;
    total++; if (bus.in_ready !== 1'b1 || rf_wa !== 4'd7) begin bad++; $display("FAIL mem_c2 got=%b/%h exp=1/7", bus.in_ready, rf_wa); end
    tick();
    drive_in(4'd4, 32'h44, 8'h00, 1'b1, 1'b0);
    #1;
    total++; if (bus.in_ready !== 1'b0 || rf_wa !== 4'd7) begin bad++; $display("FAIL mem_c3_full got=%b/%h exp=0/7", bus.in_ready, rf_wa); end
    tick();
    idle();
    #1;
    total++; if (rf_we !== 1'b1 || rf_wa !== 4'd2 || rf_wd !== 32'h22) begin bad++; $display("FAIL mem_release got=%h/%h exp=2/22", rf_wa, rf_wd); end
    tick();
    #1;
    total++; if (rf_wa !== 4'd9 || rf_wd !== 32'h99) begin bad++; $display("FAIL mem_second got=%h/%h exp=9/99", rf_wa, rf_wd); end
    tick();
  endtask

  task automatic test_same_reg();
    idle();
    mem_wr_valid = 1'b1;
    mem_wr_ra    = 4'd12;
    drive_in(4'd5, 32'd1, 8'h00, 1'b1, 1'b0);
    tick();
    drive_in(4'd5, 32'd2, 8'h00, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk_ra = 4'd5;
    #1;
    total++; if (chk_hit !== 1'b1 || chk_data !== 32'd2) begin bad++; $display("FAIL same_youngest got=%b/%h exp=1/2", chk_hit, chk_data); end
    mem_wr_valid = 1'b0;
    #1;
    total++; if (rf_wa !== 4'd5 || rf_wd !== 32'd1) begin bad++; $display("FAIL same_first got=%h/%h exp=5/1", rf_wa, rf_wd); end
    tick();
    #1;
    total++; if (rf_wa !== 4'd5 || rf_wd !== 32'd2 || chk_data !== 32'd2) begin bad++; $display("FAIL same_second got=%h/%h/%h exp=5/2/2", rf_wa, rf_wd, chk_data); end
    tick();
  endtask

  task automatic test_full_pop();
    idle();
    mem_wr_valid = 1'b1;
    drive_in(4'd1, 32'h11, 8'h00, 1'b1, 1'b0);
    tick();
    drive_in(4'd2, 32'h12, 8'h00, 1'b1, 1'b0);
    tick();
    mem_wr_valid = 1'b0;
    drive_in(4'd6, 32'h66, 8'h00, 1'b1, 1'b0);
    #1;
    total++; if (bus.in_ready !== 1'b0 || rf_we !== 1'b1) begin bad++; $display("FAIL full_refuse got=%b/%b exp=0/1", bus.in_ready, rf_we); end
    tick();
    #1;
    total++; if (bus.in_ready !== 1'b1 || rf_wd !== 32'h12) begin bad++; $display("FAIL full_accept got=%b/%h exp=1/12", bus.in_ready, rf_wd); end
    tick();
    bus.in_valid = 1'b0;
    chk_ra = 4'd6;
    #1;
    total++; if (chk_hit !== 1'b1 || rf_wd !== 32'h66) begin bad++; $display("FAIL full_late got=%b/%h exp=1/66", chk_hit, rf_wd); end
    tick();
    #1;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_drained got=%b exp=1", empty); end
  endtask

  task automatic test_flag_only();
    idle();
    drive_in(4'd8, 32'hDEAD, 8'h80, 1'b0, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    total++; if (flags !== 8'h80) begin bad++; $display("FAIL flagonly_flags got=%h exp=80", flags); end
    total++; if (empty !== 1'b1 || rf_we !== 1'b0) begin bad++; $display("FAIL flagonly_nobuf got=%b/%b exp=1/0", empty, rf_we); end
    drive_in(4'd8, 32'hBEEF, 8'h3C, 1'b0, 1'b0);
    tick();
    #1;
    total++; if (flags !== 8'h80) begin bad++; $display("FAIL flagonly_hold got=%h exp=80", flags); end
  endtask

  task automatic test_async_reset();
    idle();
    mem_wr_valid = 1'b1;
    drive_in(4'd3, 32'h33, 8'hAB, 1'b1, 1'b1);
    tick();
    drive_in(4'd4, 32'h44, 8'hCD, 1'b1, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk_ra = 4'd4;
    #1;
    total++; if (empty !== 1'b0 || flags !== 8'hCD) begin bad++; $display("FAIL areset_pre got=%b/%h exp=0/cd", empty, flags); end
    #1;
    reset = 1'b0;
    q.delete();
    m_flags = 8'h00;
    #1;
    total++; if (empty !== 1'b1 || chk_hit !== 1'b0 || flags !== 8'h00) begin bad++; $display("FAIL areset_now got=%b/%b/%h exp=1/0/00", empty, chk_hit, flags); end
    mem_wr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL areset_nowrite%0d got=%b exp=0", i, rf_we); end
      tick();
    end
  endtask

  task automatic test_random();
    logic        e_we, e_hit;
    logic [3:0]  e_wa;
    logic [31:0] e_wd, e_cd;
    for (int n = 0; n < 400; n++) begin
      bus.in_valid   = ($urandom_range(0, 9) < 7);
      bus.in_ra      = 4'($urandom_range(0, 3));
      bus.in_res     = $urandom;
      bus.in_fo      = 8'($urandom_range(0, 255));
      bus.in_wb_en   = ($urandom_range(0, 3) != 0);
      bus.in_flag_en = 1'($urandom_range(0, 1));
      mem_wr_valid   = ($urandom_range(0, 9) < 4);
      mem_wr_ra      = 4'($urandom_range(8, 15));
      mem_wr_data    = $urandom;
      chk_ra         = 4'($urandom_range(0, 3));
      #1;
      e_hit = 1'b0;
      e_cd  = '0;
      foreach (q[i]) if (q[i].ra == chk_ra) begin e_hit = 1'b1; e_cd = q[i].d; end
      if (mem_wr_valid) begin e_we = 1'b1; e_wa = mem_wr_ra; e_wd = mem_wr_data; end
      else if (q.size() > 0) begin e_we = 1'b1; e_wa = q[0].ra; e_wd = q[0].d; end
      else begin e_we = 1'b0; e_wa = '0; e_wd = '0; end
      total++; if (bus.in_ready !== (q.size() < DEPTH)) begin bad++; $display("FAIL rnd%0d_ready got=%b size=%0d", n, bus.in_ready, q.size()); end
      total++; if (empty !== (q.size() == 0)) begin bad++; $display("FAIL rnd%0d_empty got=%b size=%0d", n, empty, q.size()); end
      total++; if (flags !== m_flags) begin bad++; $display("FAIL rnd%0d_flags got=%h exp=%h", n, flags, m_flags); end
      total++; if (rf_we !== e_we || rf_wa !== e_wa || rf_wd !== e_wd) begin bad++; $display("FAIL rnd%0d_rf got=%b/%h/%h exp=%b/%h/%h", n, rf_we, rf_wa, rf_wd, e_we, e_wa, e_wd); end
      total++; if (chk_hit !== e_hit || chk_data !== e_cd) begin bad++; $display("FAIL rnd%0d_chk got=%b/%h exp=%b/%h", n, chk_hit, chk_data, e_hit, e_cd); end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #2 reset = 1'b0;
    test_reset();
    test_basic();
    test_mem_priority();
    test_same_reg();
    test_full_pop();
    test_flag_only();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
- Writeback stage directly downstream of the ALU: consumes res/fo/wb_en/flag_en for each executed instruction.
- Holds the architectural flag register.
- Buffers pending register-file writes in a small FIFO so ALU results can wait while a memory load owns the single RF write port.
- Provides hazard detection and forwarding on buffered results for the operand-fetch stage.

Parameters:
- WIDTH, 32, data/result width
- RWIDTH, 4, register index width (16 registers)
- DEPTH, 2, write-buffer entries; power of two, >=2

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  ALU result valid this cycle
- in_ready  output  1  stage can accept a result
- in_ra  input  RWIDTH  destination register index
- in_res  input  WIDTH  ALU result
- in_fo  input  8  ALU flag output
- in_wb_en  input  1  result must be written to in_ra
- in_flag_en  input  1  in_fo must update the flag register
- mem_wr_valid  input  1  load data wants the RF port (priority)
- mem_wr_ra  input  RWIDTH  load destination
- mem_wr_data  input  WIDTH  load data
- rf_we  output  1  RF write enable
- rf_wa  output  RWIDTH  RF write address
- rf_wd  output  WIDTH  RF write data
- flags  output  8  architectural flag register (feeds ALU fi)
- chk_ra  input  RWIDTH  register being read by operand fetch
- chk_hit  output  1  buffered write pending to chk_ra
- chk_data  output  WIDTH  youngest buffered value for chk_ra
- empty  output  1  no buffered writes

Behaviour:
- Reset (reset=0, async): count=0, rd/wr pointers=0, flags=8'h00; all buffer entries invalid. Thus in_ready=1, empty=1, chk_hit=0, chk_data=0, rf_we=mem_wr_valid.
- Accept: in_valid & in_ready at a rising edge.
- in_ready = (count < DEPTH). Registered-state only; no combinational path from mem_wr_valid or from the same-cycle pop. A full buffer refuses even while draining.
- On accept with in_wb_en=1: push {in_ra,in_res} at wr_ptr; wr_ptr wraps mod DEPTH.
- On accept with in_wb_en=0: nothing pushed.
- On accept with in_flag_en=1: flags<=in_fo, visible the next cycle, independent of buffer state and of in_wb_en.
- Without in_flag_en=1 at accept, flags hold.
- RF port mux (combinational):
  - If mem_wr_valid: rf_we=1, rf_wa=mem_wr_ra, rf_wd=mem_wr_data; no pop.
  - Else if count>0: rf_we=1, head entry driven, pop at edge (rd_ptr++ mod DEPTH).
  - Else: rf_we=0, rf_wa/rf_wd=0.
- Latency: an accepted result reaches the RF no earlier than the cycle after acceptance; no same-cycle bypass to the RF.
- Simultaneous push+pop: count unchanged, both pointers advance.
- Buffer order is strict FIFO; two entries with the same ra are written in program order.
- Starvation: continuous mem_wr_valid blocks draining. The buffer fills and in_ready drops; no timeout. The upstream pipeline must stall.
- chk_hit / chk_data (combinational):
  - Scan valid entries only; the incoming in_* result is not scanned.
  - chk_data = value of the youngest entry with ra==chk_ra; 0 when no hit.
  - An entry being popped this cycle still counts as a hit this cycle.
- empty = (count==0).
- Reset asserted mid-operation discards all buffered writes and clears flags immediately (asynchronous). The RF is not written with buffered data afterwards.

Decomposition:
- Shared defs package/include holds:
  - flag bit positions (shared with the ALU)
  - register index width
  - RF port priority constants
- One sub-module: wb_fifo (DEPTH x {ra,data} storage, pointers, count, associative youngest-match search).
- alu_wb_stage holds the flag register, the RF mux and the handshake.

Test Plan:
- Reset, then idle: flags=00, empty=1, in_ready=1, rf_we=0; in_valid with ra=3, res=32'h1234, wb_en=1, flag_en=1, fo=8'h05 -> next cycle flags=05, chk_ra=3 gives chk_hit=1, chk_data=1234; following cycle rf_we=1, wa=3, wd=1234, then empty=1.
- Memory priority: buffer holds ra=2; mem_wr_valid for 3 cycles with ra=7 -> rf_wa=7 for those 3 cycles; second push fills buffer so in_ready=0; entry ra=2 written the cycle mem_wr_valid drops.
- Same-register ordering: push ra=5 val=1 then ra=5 val=2 with memory busy -> chk_data=2; RF writes in order 1 then 2.
- Full with pop: DEPTH=2 full, mem idle, in_valid held -> in_ready=0 that cycle; accepted one cycle later; count never exceeds 2.
- wb_en=0, flag_en=1, fo=8'h80 -> flags=80, nothing buffered, empty stays 1.
- Async reset asserted mid-cycle with 2 entries pending -> immediately empty=1, chk_hit=0, flags=00; no buffered write after release.
